// File: rtl/muldiv_pkg.sv
// Shared types and constants for the iterative RV32M multiply/divide unit.
package muldiv_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'd0,
    OP_MULH   = 3'd1,
    OP_MULHSU = 3'd2,
    OP_MULHU  = 3'd3,
    OP_DIV    = 3'd4,
    OP_DIVU   = 3'd5,
    OP_REM    = 3'd6,
    OP_REMU   = 3'd7
  } muldiv_op_e;

  typedef enum logic [1:0] {
    S_IDLE,
    S_CALC,
    S_DONE
  } muldiv_state_e;

  localparam int unsigned MULDIV_ITER = 32;
  localparam logic [31:0] DIV_OVF_A   = 32'h8000_0000;

  // Operand A (dividend / multiplicand) is signed for everything but the unsigned ops.
  function automatic logic a_is_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_MULHSU) ||
           (op == OP_DIV) || (op == OP_REM);
  endfunction

  // Operand B is signed only for the fully signed ops (MULHSU treats it as unsigned).
  function automatic logic b_is_signed(input muldiv_op_e op);
    return (op == OP_MUL) || (op == OP_MULH) || (op == OP_DIV) || (op == OP_REM);
  endfunction

endpackage

// File: rtl/muldiv_unit.sv
// Iterative RV32M multiply/divide unit: one bit per cycle over 32 cycles,
// with a single-cycle fast path for divide-by-zero and signed overflow.
module muldiv_unit
  import muldiv_pkg::*;
#(
  parameter int unsigned XLEN = 32
) (
  input  logic            clk_i,
  input  logic            rstn_i,
  input  logic            start_i,
  input  logic [2:0]      op_i,
  input  logic [XLEN-1:0] rs1_data_i,
  input  logic [XLEN-1:0] rs2_data_i,
  input  logic [4:0]      rd_i,
  input  logic            kill_i,
  output logic            busy_o,
  output logic            done_o,
  output logic [4:0]      rd_o,
  output logic [XLEN-1:0] wr_data_o,
  output logic            wr_en_o
);

  muldiv_state_e state;
  muldiv_op_e    op_q;
  logic [4:0]    cnt;
  logic [XLEN-1:0]   a_q, b_q;
  logic              a_neg, b_neg;
  logic [2*XLEN-1:0] prod;
  logic [XLEN-1:0]   quo, rem;
  logic              busy_q, done_q;
  logic [4:0]        rd_q;
  logic [XLEN-1:0]   wr_data_q;

  // Accept-time decode
  muldiv_op_e      op_in;
  logic            a_neg_in, b_neg_in;
  logic [XLEN-1:0] a_abs_in, b_abs_in;
  logic            div_zero, div_ovf, fast;
  logic [XLEN-1:0] fast_res;

  // Iteration datapath
  logic [XLEN:0]     add_sum, addend;
  logic [2*XLEN-1:0] prod_nx;
  logic [XLEN:0]     rem_sh, rem_diff;
  logic [XLEN-1:0]   rem_nx, quo_nx;
  logic [2*XLEN-1:0] prod_s;
  logic [XLEN-1:0]   quo_s, rem_s, result;

  // Decode operands at accept: sign flags, magnitudes and fast-path special cases
  always_comb begin
    op_in    = muldiv_op_e'(op_i);
    a_neg_in = a_is_signed(op_in) & rs1_data_i[XLEN-1];
    b_neg_in = b_is_signed(op_in) & rs2_data_i[XLEN-1];
    a_abs_in = a_neg_in ? -rs1_data_i : rs1_data_i;
    b_abs_in = b_neg_in ? -rs2_data_i : rs2_data_i;
    div_zero = op_i[2] && (rs2_data_i == '0);
    div_ovf  = ((op_in == OP_DIV) || (op_in == OP_REM)) &&
               (rs1_data_i == DIV_OVF_A) && (rs2_data_i == '1);
    fast     = div_zero | div_ovf;
    fast_res = '0;
    if (div_zero) begin
      fast_res = op_i[1] ? rs1_data_i : '1;
    end else if (div_ovf) begin
      fast_res = op_i[1] ? '0 : DIV_OVF_A;
    end
  end

  // One shift-add multiply step and one restoring divide step, plus sign fix-up of the final values
  always_comb begin
    addend   = prod[0] ? {1'b0, a_q} : '0;
    add_sum  = {1'b0, prod[2*XLEN-1:XLEN]} + addend;
    prod_nx  = {add_sum, prod[XLEN-1:1]};

    rem_sh   = {rem, quo[XLEN-1]};
    rem_diff = rem_sh - {1'b0, b_q};
    if (rem_diff[XLEN]) begin
      rem_nx = rem_sh[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b0};
    end else begin
      rem_nx = rem_diff[XLEN-1:0];
      quo_nx = {quo[XLEN-2:0], 1'b1};
    end

    prod_s = (a_neg ^ b_neg) ? -prod_nx : prod_nx;
    quo_s  = (a_neg ^ b_neg) ? -quo_nx : quo_nx;
    rem_s  = a_neg ? -rem_nx : rem_nx;

    case (op_q)
      OP_MUL:                       result = prod_s[XLEN-1:0];
      OP_MULH, OP_MULHSU, OP_MULHU: result = prod_s[2*XLEN-1:XLEN];
      OP_DIV, OP_DIVU:              result = quo_s;
      OP_REM, OP_REMU:              result = rem_s;
      default:                      result = '0;
    endcase
  end

  // Control FSM with registered busy/done/rd/result
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      state     <= S_IDLE;
      op_q      <= OP_MUL;
      cnt       <= '0;
      a_q       <= '0;
      b_q       <= '0;
      a_neg     <= 1'b0;
      b_neg     <= 1'b0;
      prod      <= '0;
      quo       <= '0;
      rem       <= '0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      rd_q      <= '0;
      wr_data_q <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          done_q <= 1'b0;
          if (start_i) begin
            op_q   <= op_in;
            rd_q   <= rd_i;
            a_neg  <= a_neg_in;
            b_neg  <= b_neg_in;
            busy_q <= 1'b1;
            if (fast) begin
              wr_data_q <= fast_res;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end else begin
              a_q   <= a_abs_in;
              b_q   <= b_abs_in;
              prod  <= {{XLEN{1'b0}}, b_abs_in};
              quo   <= a_abs_in;
              rem   <= '0;
              cnt   <= 5'(MULDIV_ITER - 1);
              state <= S_CALC;
            end
          end
        end
        S_CALC: begin
          if (kill_i) begin
            busy_q <= 1'b0;
            state  <= S_IDLE;
          end else begin
            prod <= prod_nx;
            quo  <= quo_nx;
            rem  <= rem_nx;
            // The last step's result is sign-fixed from the next-state values so it lands on the DONE edge
            if (cnt == '0) begin
              wr_data_q <= result;
              done_q    <= 1'b1;
              state     <= S_DONE;
            end else begin
              cnt <= cnt - 5'd1;
            end
          end
        end
        S_DONE: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
        default: begin
          busy_q <= 1'b0;
          done_q <= 1'b0;
          state  <= S_IDLE;
        end
      endcase
    end
  end

  // A flush in the completion cycle suppresses the pulse and the write
  assign done_o    = done_q & ~kill_i;
  assign wr_en_o   = done_o & (rd_q != '0);
  assign busy_o    = busy_q;
  assign rd_o      = rd_q;
  assign wr_data_o = wr_data_q;

endmodule
